// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 14
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          gnt0;
   logic          rvalid0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          gnt1;
   logic          rvalid1;
   logic [DW-1:0] rdata1;

   logic [DW-1:0] mem_in;
   logic          mem_load;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_out;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_out,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output mem_in, mem_load, mem_address
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_out,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  mem_in, mem_load, mem_address
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter with bounded burst in front of a single-port RAM
module mem_arbiter #(
   parameter int DW        = 16,
   parameter int AW        = 14,
   parameter int MAX_BURST = 4
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int            CW      = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

   logic          owner;
   logic [CW-1:0] count;
   logic          grant;
   logic          winner;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Grants are gated by reset so an in-flight write never reaches the RAM.
   always_comb begin
      grant  = 1'b0;
      winner = owner;
      if (reset) begin
         if (bus.req0 && bus.req1) begin
            grant  = 1'b1;
            winner = (count < MAX_CNT) ? owner : ~owner;
         end else if (bus.req0) begin
            grant  = 1'b1;
            winner = 1'b0;
         end else if (bus.req1) begin
            grant  = 1'b1;
            winner = 1'b1;
         end
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = bus.addr0;
      sel_wdata = bus.wdata0;
      if (grant && winner) begin
         sel_we    = bus.we1;
         sel_addr  = bus.addr1;
         sel_wdata = bus.wdata1;
      end else if (grant) begin
         sel_we    = bus.we0;
      end
   end

   assign bus.gnt0        = grant & ~winner;
   assign bus.gnt1        = grant & winner;
   assign bus.mem_load    = sel_we;
   assign bus.mem_address = sel_addr;
   assign bus.mem_in      = sel_wdata;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         owner       <= 1'b0;
         count       <= '0;
         bus.rvalid0 <= 1'b0;
         bus.rvalid1 <= 1'b0;
         bus.rdata0  <= '0;
         bus.rdata1  <= '0;
      end else begin
         bus.rvalid0 <= bus.gnt0 & ~bus.we0;
         bus.rvalid1 <= bus.gnt1 & ~bus.we1;
         if (bus.gnt0 && !bus.we0)
            bus.rdata0 <= bus.mem_out;
         if (bus.gnt1 && !bus.we1)
            bus.rdata1 <= bus.mem_out;
         if (grant) begin
            if (winner == owner) begin
               if (count < MAX_CNT)
                  count <= count + CW'(1);
            end else begin
               owner <= winner;
               count <= CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
   logic clock;
   logic reset;

   mem_arbiter_if #(.DW(16), .AW(14)) bus ();
   mem_arbiter_if #(.DW(16), .AW(14)) bus_b ();

   mem_arbiter #(.DW(16), .AW(14), .MAX_BURST(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   mem_arbiter #(.DW(16), .AW(14), .MAX_BURST(1)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] ram_a   [0:16383];
   logic [15:0] exp_mem [0:16383];
   logic [16:0] sb0 [$];
   logic [16:0] sb1 [$];
   logic [16:0] e0, e1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] init_val(input int a);
      return 16'(a) ^ 16'hC3C3;
   endfunction

   function automatic logic [15:0] b_val(input logic [13:0] a);
      return {2'b00, a} ^ 16'h5A5A;
   endfunction

   assign bus.mem_out   = ram_a[bus.mem_address];
   assign bus_b.mem_out = b_val(bus_b.mem_address);

   initial begin
      for (int i = 0; i < 16384; i++) ram_a[i] = init_val(i);
      forever begin
         @(posedge clock);
         if (bus.mem_load) ram_a[bus.mem_address] <= bus.mem_in;
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic drive0(input logic req, input logic we, input int addr, input logic [15:0] wdata);
      bus.req0 = req; bus.we0 = we; bus.addr0 = 14'(addr); bus.wdata0 = wdata;
   endtask

   task automatic drive1(input logic req, input logic we, input int addr, input logic [15:0] wdata);
      bus.req1 = req; bus.we1 = we; bus.addr1 = 14'(addr); bus.wdata1 = wdata;
   endtask

   // w: expected winner this cycle, -1 for idle
   task automatic push_expect(input int w);
      logic v0, v1;
      v0 = (w == 0) && !bus.we0;
      v1 = (w == 1) && !bus.we1;
      sb0.push_back({v0, exp_mem[bus.addr0]});
      sb1.push_back({v1, exp_mem[bus.addr1]});
      if (w == 0 && bus.we0) exp_mem[bus.addr0] = bus.wdata0;
      if (w == 1 && bus.we1) exp_mem[bus.addr1] = bus.wdata1;
   endtask

   task automatic apply_reset();
      drive0(0, 0, 0, 16'h0);
      drive1(0, 0, 0, 16'h0);
      bus_b.req0 = 0; bus_b.req1 = 0;
      reset = 1'b0;
      sb0.delete(); sb1.delete();
      next_cycle();
      next_cycle();
      reset = 1'b1;
      sb0.push_back(17'h0);
      sb1.push_back(17'h0);
   endtask

   task automatic test_reset();
      drive0(1, 1, 3, 16'hAAAA);
      drive1(1, 0, 4, 16'h0);
      #3;
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %0b want 0", bus.gnt0); end
      checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %0b want 0", bus.gnt1); end
      checks++; if (bus.mem_load !== 1'b0) begin errors++; $display("FAIL rst_mem_load got %0b want 0", bus.mem_load); end
      checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0b%0b want 00", bus.rvalid0, bus.rvalid1); end
      checks++; if (bus.rdata0 !== 16'h0 || bus.rdata1 !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h %h want 0000 0000", bus.rdata0, bus.rdata1); end
      next_cycle();
      checks++; if (ram_a[3] !== init_val(3)) begin errors++; $display("FAIL rst_ram3 got %h want %h", ram_a[3], init_val(3)); end
      apply_reset();
   endtask

   task automatic test_write_read();
      apply_reset();
      drive0(1, 1, 5, 16'h1234);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid0 !== e0[16]) begin errors++; $display("FAIL wr_rvalid0 got %0b want %0b", bus.rvalid0, e0[16]); end
      checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got %0b%0b want 10", bus.gnt0, bus.gnt1); end
      checks++; if (bus.mem_load !== 1'b1) begin errors++; $display("FAIL wr_mem_load got %0b want 1", bus.mem_load); end
      checks++; if (bus.mem_address !== 14'd5 || bus.mem_in !== 16'h1234) begin errors++; $display("FAIL wr_bus got %0d %h want 5 1234", bus.mem_address, bus.mem_in); end
      push_expect(0);
      next_cycle();
      drive0(1, 0, 5, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid0 !== e0[16]) begin errors++; $display("FAIL rd_rvalid0 got %0b want %0b", bus.rvalid0, e0[16]); end
      checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0 got %0b want 1", bus.gnt0); end
      checks++; if (bus.mem_load !== 1'b0) begin errors++; $display("FAIL rd_mem_load got %0b want 0", bus.mem_load); end
      push_expect(0);
      next_cycle();
      drive0(0, 0, 0, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid0 !== e0[16]) begin errors++; $display("FAIL rsp_rvalid0 got %0b want %0b", bus.rvalid0, e0[16]); end
      checks++; if (bus.rdata0 !== e0[15:0] || bus.rdata0 !== 16'h1234) begin errors++; $display("FAIL rsp_rdata0 got %h want %h", bus.rdata0, e0[15:0]); end
      checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL idle_gnt got %0b%0b want 00", bus.gnt0, bus.gnt1); end
      push_expect(-1);
      next_cycle();
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid0 !== e0[16]) begin errors++; $display("FAIL idle_rvalid0 got %0b want %0b", bus.rvalid0, e0[16]); end
      checks++; if (bus.rdata0 !== 16'h1234) begin errors++; $display("FAIL hold_rdata0 got %h want 1234", bus.rdata0); end
      push_expect(-1);
      next_cycle();
   endtask

   // k: cycle index since reset; a0/a1 advance only when granted
   task automatic test_contention();
      int a0, a1, w;
      a0 = 100; a1 = 200;
      apply_reset();
      for (int k = 0; k < 25; k++) begin
         if (k < 24) begin
            drive0(1, 0, a0, 16'h0);
            drive1(1, 0, a1, 16'h0);
         end else begin
            drive0(0, 0, 0, 16'h0);
            drive1(0, 0, 0, 16'h0);
         end
         #4;
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         checks++; if (bus.rvalid0 !== e0[16] || bus.rvalid1 !== e1[16]) begin errors++; $display("FAIL cont_rvalid k=%0d got %0b%0b want %0b%0b", k, bus.rvalid0, bus.rvalid1, e0[16], e1[16]); end
         if (e0[16]) begin checks++; if (bus.rdata0 !== e0[15:0]) begin errors++; $display("FAIL cont_rdata0 k=%0d got %h want %h", k, bus.rdata0, e0[15:0]); end end
         if (e1[16]) begin checks++; if (bus.rdata1 !== e1[15:0]) begin errors++; $display("FAIL cont_rdata1 k=%0d got %h want %h", k, bus.rdata1, e1[15:0]); end end
         w = (k < 24) ? (k / 4) % 2 : -1;
         checks++; if (bus.gnt0 !== (w == 0) || bus.gnt1 !== (w == 1)) begin errors++; $display("FAIL cont_gnt k=%0d got %0b%0b want %0b%0b", k, bus.gnt0, bus.gnt1, w == 0, w == 1); end
         push_expect(w);
         if (w == 0) a0++;
         if (w == 1) a1++;
         next_cycle();
      end
   endtask

   task automatic test_join();
      int a0, a1, w;
      a0 = 400; a1 = 300;
      apply_reset();
      for (int k = 0; k < 17; k++) begin
         drive0(k >= 10 && k < 16, 0, a0, 16'h0);
         drive1(k < 16, 0, a1, 16'h0);
         #4;
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         checks++; if (bus.rvalid0 !== e0[16] || bus.rvalid1 !== e1[16]) begin errors++; $display("FAIL join_rvalid k=%0d got %0b%0b want %0b%0b", k, bus.rvalid0, bus.rvalid1, e0[16], e1[16]); end
         if (e1[16]) begin checks++; if (bus.rdata1 !== e1[15:0]) begin errors++; $display("FAIL join_rdata1 k=%0d got %h want %h", k, bus.rdata1, e1[15:0]); end end
         if (e0[16]) begin checks++; if (bus.rdata0 !== e0[15:0]) begin errors++; $display("FAIL join_rdata0 k=%0d got %h want %h", k, bus.rdata0, e0[15:0]); end end
         w = (k < 10) ? 1 : (k < 14) ? 0 : (k < 16) ? 1 : -1;
         checks++; if (bus.gnt0 !== (w == 0) || bus.gnt1 !== (w == 1)) begin errors++; $display("FAIL join_gnt k=%0d got %0b%0b want %0b%0b", k, bus.gnt0, bus.gnt1, w == 0, w == 1); end
         push_expect(w);
         if (w == 0) a0++;
         if (w == 1) a1++;
         next_cycle();
      end
   endtask

   task automatic test_same_addr();
      apply_reset();
      drive0(1, 1, 7, 16'hBEEF);
      drive1(1, 0, 7, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL same_gnt_a got %0b%0b want 10", bus.gnt0, bus.gnt1); end
      push_expect(0);
      next_cycle();
      drive0(0, 0, 0, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b1) begin errors++; $display("FAIL same_gnt_b got %0b%0b want 01", bus.gnt0, bus.gnt1); end
      checks++; if (bus.rvalid1 !== e1[16]) begin errors++; $display("FAIL same_rvalid1_a got %0b want %0b", bus.rvalid1, e1[16]); end
      push_expect(1);
      next_cycle();
      drive1(0, 0, 0, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid1 !== e1[16] || bus.rvalid1 !== 1'b1) begin errors++; $display("FAIL same_rvalid1 got %0b want %0b", bus.rvalid1, e1[16]); end
      checks++; if (bus.rdata1 !== e1[15:0] || bus.rdata1 !== 16'hBEEF) begin errors++; $display("FAIL same_rdata1 got %h want beef", bus.rdata1); end
      push_expect(-1);
      next_cycle();
   endtask

   task automatic test_reset_midburst();
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         drive1(1, 0, 20 + k, 16'h0);
         #4;
         e0 = sb0.pop_front(); e1 = sb1.pop_front();
         checks++; if (bus.gnt1 !== 1'b1) begin errors++; $display("FAIL mid_gnt1 k=%0d got %0b want 1", k, bus.gnt1); end
         push_expect(1);
         next_cycle();
      end
      drive1(0, 0, 0, 16'h0);
      drive0(1, 1, 9, 16'h7777);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid1 !== e1[16] || bus.rdata1 !== e1[15:0]) begin errors++; $display("FAIL mid_rsp1 got %0b %h want %0b %h", bus.rvalid1, bus.rdata1, e1[16], e1[15:0]); end
      checks++; if (bus.mem_load !== 1'b1) begin errors++; $display("FAIL mid_load_pre got %0b want 1", bus.mem_load); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (bus.mem_load !== 1'b0 || bus.gnt0 !== 1'b0) begin errors++; $display("FAIL mid_load got %0b gnt0 %0b want 0 0", bus.mem_load, bus.gnt0); end
      checks++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %0b%0b want 00", bus.rvalid0, bus.rvalid1); end
      sb0.delete(); sb1.delete();
      next_cycle();
      reset = 1'b1;
      checks++; if (ram_a[9] !== init_val(9)) begin errors++; $display("FAIL mid_ram9 got %h want %h", ram_a[9], init_val(9)); end
      drive0(1, 0, 9, 16'h0);
      drive1(1, 0, 22, 16'h0);
      #4;
      checks++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin errors++; $display("FAIL mid_restart_gnt got %0b%0b want 10", bus.gnt0, bus.gnt1); end
      push_expect(0);
      next_cycle();
      drive0(0, 0, 0, 16'h0);
      drive1(0, 0, 0, 16'h0);
      #4;
      e0 = sb0.pop_front(); e1 = sb1.pop_front();
      checks++; if (bus.rvalid0 !== e0[16] || bus.rdata0 !== e0[15:0] || bus.rdata0 !== init_val(9)) begin errors++; $display("FAIL mid_rdata0 got %0b %h want 1 %h", bus.rvalid0, bus.rdata0, init_val(9)); end
      next_cycle();
   endtask

   task automatic test_burst1();
      int prev, w;
      apply_reset();
      prev = -1;
      bus_b.we0 = 0; bus_b.addr0 = 14'd40; bus_b.wdata0 = 16'h0;
      bus_b.we1 = 0; bus_b.addr1 = 14'd41; bus_b.wdata1 = 16'h0;
      for (int k = 0; k < 8; k++) begin
         bus_b.req0 = 1; bus_b.req1 = 1;
         #4;
         w = k % 2;
         checks++; if (bus_b.gnt0 !== (w == 0) || bus_b.gnt1 !== (w == 1)) begin errors++; $display("FAIL b1_gnt k=%0d got %0b%0b want %0b%0b", k, bus_b.gnt0, bus_b.gnt1, w == 0, w == 1); end
         checks++; if (bus_b.rvalid0 !== (prev == 0) || bus_b.rvalid1 !== (prev == 1)) begin errors++; $display("FAIL b1_rvalid k=%0d got %0b%0b want %0b%0b", k, bus_b.rvalid0, bus_b.rvalid1, prev == 0, prev == 1); end
         if (prev == 0) begin checks++; if (bus_b.rdata0 !== b_val(14'd40)) begin errors++; $display("FAIL b1_rdata0 got %h want %h", bus_b.rdata0, b_val(14'd40)); end end
         if (prev == 1) begin checks++; if (bus_b.rdata1 !== b_val(14'd41)) begin errors++; $display("FAIL b1_rdata1 got %h want %h", bus_b.rdata1, b_val(14'd41)); end end
         prev = w;
         next_cycle();
      end
      bus_b.req0 = 0; bus_b.req1 = 0;
   endtask

   initial begin
      reset = 1'b0;
      drive0(0, 0, 0, 16'h0);
      drive1(0, 0, 0, 16'h0);
      bus_b.req0 = 0; bus_b.we0 = 0; bus_b.addr0 = '0; bus_b.wdata0 = '0;
      bus_b.req1 = 0; bus_b.we1 = 0; bus_b.addr1 = '0; bus_b.wdata1 = '0;
      for (int i = 0; i < 16384; i++) exp_mem[i] = init_val(i);
      test_reset();
      test_write_read();
      test_contention();
      test_join();
      test_same_addr();
      test_reset_midburst();
      test_burst1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
